// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - csRISC fetch stage: PC, imem req/valid handshake, decode-side valid/ready
// Redirects during an outstanding request are parked in pend_pc until the memory completes.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [5:0]         out_opcode,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DISCARD,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pend_pc;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_out_instr;
  logic [5:0]         r_out_opcode;
  logic [ADDR_W-1:0]  r_out_pc;
  logic [ADDR_W-1:0]  r_out_pc_plus4;

  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [ADDR_W-1:0]  w_pend_nxt;
  logic               w_out_valid_nxt;
  logic               w_load_out;
  logic [ADDR_W-1:0]  w_redirect_pc;
  logic [ADDR_W-1:0]  w_pc_plus4;
  logic               w_unused;

  // Targets are always word aligned; the low bits from the branch unit are dropped.
  assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];
  assign w_pc_plus4    = r_pc + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_nxt      = r_pend_pc;
    w_out_valid_nxt = r_out_valid;
    w_load_out      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          if (imem_valid) begin
            w_pc_nxt = w_redirect_pc;
          end else begin
            w_pend_nxt  = w_redirect_pc;
            w_state_nxt = S_DISCARD;
          end
        end else if (imem_valid) begin
          w_load_out      = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_pc_nxt        = w_pc_plus4;
          w_state_nxt     = S_HOLD;
        end
      end
      S_DISCARD: begin
        if (imem_valid) begin
          w_pc_nxt    = redirect ? w_redirect_pc : r_pend_pc;
          w_state_nxt = S_FETCH;
        end else if (redirect) begin
          w_pend_nxt = w_redirect_pc;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = w_redirect_pc;
          w_state_nxt     = S_FETCH;
        end else if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc           <= RESET_PC;
      r_pend_pc      <= RESET_PC;
      r_out_valid    <= 1'b0;
      r_out_instr    <= '0;
      r_out_opcode   <= '0;
      r_out_pc       <= '0;
      r_out_pc_plus4 <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_pend_pc   <= w_pend_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_load_out) begin
        r_out_instr    <= imem_rdata;
        r_out_opcode   <= imem_rdata[31:26];
        r_out_pc       <= r_pc;
        r_out_pc_plus4 <= w_pc_plus4;
      end
    end
  end

  assign imem_req     = (r_state == S_FETCH) || (r_state == S_DISCARD);
  assign imem_addr    = r_pc;
  assign out_valid    = r_out_valid;
  assign out_instr    = r_out_instr;
  assign out_opcode   = r_out_opcode;
  assign out_pc       = r_out_pc;
  assign out_pc_plus4 = r_out_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  instruction_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_opcode(out_opcode),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] p4;
    int          cyc;
  } xfer_t;

  xfer_t       got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 0;
  int stable_err = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[7:2] ^ 6'h15, a[27:2]};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: completes mem_lat cycles after a request starts; checks address stability while pending.
  initial begin
    bit          req_prev = 0;
    bit          done_prev = 0;
    logic [31:0] addr_prev = 0;
    int          mcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (req_prev && !done_prev && imem_req && imem_addr !== addr_prev) stable_err++;
      if (!imem_req || !req_prev || done_prev) mcnt = 0;
      else mcnt++;
      imem_valid = imem_req && (mcnt >= mem_lat);
      imem_rdata = imem_valid ? instr_of(imem_addr) : 32'hDEAD_BEEF;
      req_prev  = imem_req;
      done_prev = imem_req && imem_valid;
      addr_prev = imem_addr;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && out_ready) begin
        xfer_t x;
        x.pc = out_pc; x.instr = out_instr; x.op = out_opcode; x.p4 = out_pc_plus4; x.cyc = cyc;
        got_q.push_back(x);
      end
      if (imem_req && imem_valid) req_log.push_back(imem_addr);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    step(); step();
    got_q.delete(); exp_q.delete(); req_log.delete();
  endtask

  task automatic wait_out_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic wait_got(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (got_q.size() >= n) begin ok = 1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok; xfer_t g; logic [31:0] e, ei; int c[3];
    do_reset(); mem_lat = 0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rst_addr got %h want 100", imem_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", out_instr); end
    checks++; if (out_opcode !== 6'h0) begin errors++; $display("FAIL rst_opcode got %h want 0", out_opcode); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", out_pc); end
    checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h want 0", out_pc_plus4); end
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL first_req got %0b/%h want 1/100", imem_req, imem_addr); end
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    wait_got(3, ok);
    out_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL zw_timeout got %0d xfers want 3", got_q.size()); end
    for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); ei = instr_of(e); c[i] = g.cyc;
      checks++; if (g.pc !== e) begin errors++; $display("FAIL zw_pc got %h want %h", g.pc, e); end
      checks++; if (g.instr !== ei) begin errors++; $display("FAIL zw_instr got %h want %h", g.instr, ei); end
      checks++; if (g.op !== ei[31:26]) begin errors++; $display("FAIL zw_opcode got %h want %h", g.op, ei[31:26]); end
      checks++; if (g.p4 !== e + 32'd4) begin errors++; $display("FAIL zw_pc4 got %h want %h", g.p4, e + 32'd4); end
      checks++; if (req_log.size() <= i || req_log[i] !== e) begin errors++; $display("FAIL zw_req_addr idx %0d want %h", i, e); end
    end
    checks++; if (c[2] - c[1] != 2 || c[1] - c[0] != 2) begin errors++; $display("FAIL zw_rate got %0d,%0d want 2,2", c[1] - c[0], c[2] - c[1]); end
  endtask

  task automatic test_back_to_back();
    bit ok; xfer_t g; logic [31:0] e; int last;
    do_reset(); mem_lat = 2; rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    wait_got(4, ok);
    out_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d want 4", got_q.size()); end
    last = -1;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e || g.instr !== instr_of(e)) begin errors++; $display("FAIL b2b_data got %h/%h want %h/%h", g.pc, g.instr, e, instr_of(e)); end
      if (last >= 0) begin
        checks++; if (g.cyc - last != 4) begin errors++; $display("FAIL b2b_rate got %0d want 4", g.cyc - last); end
      end
      last = g.cyc;
    end
  endtask

  task automatic test_backpressure();
    bit ok; xfer_t g;
    do_reset(); mem_lat = 0; rst_n = 1'b1;
    wait_out_valid(ok);
    checks++; if (!ok || out_pc !== 32'h100) begin errors++; $display("FAIL bp_first got %0b/%h want 1/100", ok, out_pc); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== instr_of(32'h100) || imem_req !== 1'b0) begin
        errors++; $display("FAIL bp_stall got v%0b pc %h instr %h req %0b want 1/100/%h/0", out_valid, out_pc, out_instr, imem_req, instr_of(32'h100));
      end
    end
    exp_q.push_back(32'h100);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL bp_refetch got v%0b req %0b addr %h want 0/1/104", out_valid, imem_req, imem_addr); end
    wait_out_valid(ok);
    checks++; if (!ok || out_pc !== 32'h104) begin errors++; $display("FAIL bp_next got %0b/%h want 1/104", ok, out_pc); end
    step(); step();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL bp_count got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++; if (g.pc !== exp_q[0]) begin errors++; $display("FAIL bp_xfer got %h want %h", g.pc, exp_q[0]); end
    end
  endtask

  task automatic test_redirect_hold();
    bit ok; xfer_t g; logic [31:0] e;
    do_reset(); mem_lat = 0; rst_n = 1'b1;
    wait_out_valid(ok);
    exp_q.push_back(32'h100);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    wait_out_valid(ok);
    checks++; if (!ok || out_pc !== 32'h104) begin errors++; $display("FAIL rh_hold got %0b/%h want 1/104", ok, out_pc); end
    redirect = 1'b1; redirect_pc = 32'h203; step(); redirect = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rh_target got v%0b req %0b addr %h want 0/1/200", out_valid, imem_req, imem_addr); end
    wait_out_valid(ok);
    checks++; if (!ok || out_pc !== 32'h200 || out_instr !== instr_of(32'h200)) begin errors++; $display("FAIL rh_data got %h/%h want 200/%h", out_pc, out_instr, instr_of(32'h200)); end
    exp_q.push_back(32'h200);
    redirect = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1; step(); redirect = 1'b0; out_ready = 1'b0;
    checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL rh_ready_target got %h want 300", imem_addr); end
    wait_out_valid(ok);
    checks++; if (!ok || out_pc !== 32'h300) begin errors++; $display("FAIL rh_ready_data got %h want 300", out_pc); end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rh_count got %0d want 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e) begin errors++; $display("FAIL rh_xfer got %h want %h", g.pc, e); end
    end
  endtask

  task automatic test_redirect_latency();
    bit ok; xfer_t g;
    do_reset(); mem_lat = 3; rst_n = 1'b1; out_ready = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h400; step(); redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rl_hold1 got %0b/%h want 1/100", imem_req, imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rl_hold2 got %h want 100", imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h400) begin errors++; $display("FAIL rl_target got %h want 400", imem_addr); end
    exp_q.push_back(32'h400);
    wait_got(1, ok);
    out_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rl_timeout got %0d want 1", got_q.size()); end
    step();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rl_count got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++; if (g.pc !== exp_q[0] || g.instr !== instr_of(exp_q[0])) begin errors++; $display("FAIL rl_xfer got %h/%h want %h", g.pc, g.instr, exp_q[0]); end
    end
    checks++; if (req_log.size() < 2 || req_log[0] !== 32'h100 || req_log[1] !== 32'h400) begin errors++; $display("FAIL rl_reqs got %0d entries want 100,400", req_log.size()); end

    do_reset(); mem_lat = 3; rst_n = 1'b1; out_ready = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h400; step();
    redirect_pc = 32'h500; step(); redirect = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h500) begin errors++; $display("FAIL rl_latest got %h want 500", imem_addr); end

    do_reset(); mem_lat = 3; rst_n = 1'b1; out_ready = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h400; step(); redirect = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h600; step(); redirect = 1'b0;
    checks++; if (imem_addr !== 32'h600) begin errors++; $display("FAIL rl_same_cycle got %h want 600", imem_addr); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] ei;
    do_reset(); mem_lat = 0; rst_n = 1'b1;
    wait_out_valid(ok);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; step(); redirect = 1'b0;
    wait_out_valid(ok);
    ei = instr_of(32'hFFFF_FFFC);
    checks++; if (!ok || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", out_pc); end
    checks++; if (out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", out_pc_plus4); end
    checks++; if (out_opcode !== ei[31:26]) begin errors++; $display("FAIL wrap_opcode got %h want %h", out_opcode, ei[31:26]); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h want 0", imem_addr); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    wait_out_valid(ok);
    checks++; if (!ok || out_pc !== 32'h0) begin errors++; $display("FAIL wrap_fetch0 got %h want 0", out_pc); end
  endtask

  task automatic test_reset_mid();
    bit ok; xfer_t g;
    do_reset(); mem_lat = 2; rst_n = 1'b1; out_ready = 1'b1;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL rm_state got v%0b req %0b addr %h want 0/0/100", out_valid, imem_req, imem_addr); end
    checks++; if (out_instr !== 32'h0 || out_opcode !== 6'h0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rm_zero got %h/%h/%h/%h want 0", out_instr, out_opcode, out_pc, out_pc_plus4); end
    step();
    checks++; if (got_q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_xfer got %0d/%0b want 0/0", got_q.size(), out_valid); end
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rm_restart got %0b/%h want 1/100", imem_req, imem_addr); end
    exp_q.push_back(32'h100);
    wait_got(1, ok);
    out_ready = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rm_timeout got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++; if (g.pc !== exp_q[0] || g.instr !== instr_of(exp_q[0])) begin errors++; $display("FAIL rm_xfer got %h/%h want %h", g.pc, g.instr, exp_q[0]); end
    end
  endtask

  task automatic test_addr_stable();
    checks++; if (stable_err != 0) begin errors++; $display("FAIL addr_stable got %0d changes want 0", stable_err); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect_hold();
    test_redirect_latency();
    test_wrap();
    test_reset_mid();
    test_addr_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
